instr_word_tx: RTL and testbench

Transmit side of the instruction-word link. Accepts one 72-bit instruction word (address, data, opcode) per valid/ready handshake and serializes it onto an 8-bit byte stream with start/end-of-frame markers and an optional XOR checksum byte. Sits between the instruction source and the byte-wide link whose far end reassembles words into the instruction register.

---
 rtl/instr_word_tx.sv | 142 ++++++++++++++
 tb/tb_instr_word_tx.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_word_tx.sv
// instr_word_tx: transmit side of the instruction-word link.
// Takes one 72-bit word {address, data, opcode} per valid/ready handshake and
// serializes it as opcode, address MSB..LSB, data MSB..LSB and an optional
// XOR checksum byte, framed with start/end-of-frame markers.
module instr_word_tx #(
    parameter bit          SEND_CHECKSUM = 1'b1,
    parameter int unsigned GAP_CYCLES    = 0
) (
    input  logic        clock,
    input  logic        resetN,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [71:0] in_word,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_byte,
    output logic        tx_sof,
    output logic        tx_eof,
    output logic        busy,
    output logic [15:0] frames_sent
);

    // Index of the final byte of a frame: the checksum, or the last data byte.
    localparam logic [3:0] LAST = SEND_CHECKSUM ? 4'd9 : 4'd8;
    // GAP counts down to zero, so it is loaded with one less than its length.
    localparam logic [3:0] GAP_LOAD = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t      state_q;
    logic [71:0] word_q;
    logic [3:0]  idx_q;
    logic [3:0]  gap_q;
    logic [15:0] frames_q;
    logic        in_ready_q;
    logic        tx_valid_q;
    logic        busy_q;

    logic [7:0]  checksum_d;
    logic [7:0]  byte_d;

    // Checksum is recomputed from the held word every cycle, so stalls cannot disturb it.
    always_comb begin
        checksum_d = word_q[7:0]   ^ word_q[71:64] ^ word_q[63:56] ^ word_q[55:48] ^
                     word_q[47:40] ^ word_q[39:32] ^ word_q[31:24] ^ word_q[23:16] ^
                     word_q[15:8];
    end

    // Select the frame byte at the current index.
    always_comb begin
        // NOTE: default assignment first, so no path through the case leaves byte_d unassigned (no latch).
        byte_d = 8'h00;
        case (idx_q)
            4'd0:    byte_d = word_q[7:0];
            4'd1:    byte_d = word_q[71:64];
            4'd2:    byte_d = word_q[63:56];
            4'd3:    byte_d = word_q[55:48];
            4'd4:    byte_d = word_q[47:40];
            4'd5:    byte_d = word_q[39:32];
            4'd6:    byte_d = word_q[31:24];
            4'd7:    byte_d = word_q[23:16];
            4'd8:    byte_d = word_q[15:8];
            4'd9:    byte_d = SEND_CHECKSUM ? checksum_d : 8'h00;
            default: byte_d = 8'h00;
        endcase
    end

    // Frame FSM: holding register, byte index, gap timer, frame counter and registered flags.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            // NOTE: the holding register is reset too, so tx_byte and the checksum never expose X after reset.
            state_q    <= S_IDLE;
            word_q     <= '0;
            idx_q      <= '0;
            gap_q      <= '0;
            frames_q   <= '0;
            in_ready_q <= 1'b1;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register sees the pre-edge values.
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        word_q     <= in_word;
                        idx_q      <= '0;
                        state_q    <= S_SEND;
                        in_ready_q <= 1'b0;
                        tx_valid_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                S_SEND: begin
                    if (tx_ready) begin
                        if (idx_q == LAST) begin
                            frames_q   <= frames_q + 16'd1;
                            tx_valid_q <= 1'b0;
                            if (GAP_CYCLES > 0) begin
                                state_q <= S_GAP;
                                gap_q   <= GAP_LOAD;
                            end else begin
                                state_q    <= S_IDLE;
                                in_ready_q <= 1'b1;
                                busy_q     <= 1'b0;
                            end
                        end else begin
                            idx_q <= idx_q + 4'd1;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_q == 4'd0) begin
                        state_q    <= S_IDLE;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                    end else begin
                        gap_q <= gap_q - 4'd1;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    in_ready_q <= 1'b1;
                    tx_valid_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign tx_valid    = tx_valid_q;
    assign busy        = busy_q;
    assign frames_sent = frames_q;
    assign tx_byte     = tx_valid_q ? byte_d : 8'h00;
    assign tx_sof      = tx_valid_q && (idx_q == 4'd0);
    assign tx_eof      = tx_valid_q && (idx_q == LAST);

endmodule

// File: tb/tb_instr_word_tx.sv
// Bench for instr_word_tx: a default instance (checksum on, no gap) and a
// second instance with SEND_CHECKSUM=0, GAP_CYCLES=2. Expected bytes come
// from a field-level model of the frame format.
module tb_instr_word_tx;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic resetN;

    logic        in_valid0, in_ready0, tx_valid0, tx_ready0, tx_sof0, tx_eof0, busy0;
    logic [71:0] in_word0;
    logic [7:0]  tx_byte0;
    logic [15:0] frames0;

    logic        in_valid1, in_ready1, tx_valid1, tx_ready1, tx_sof1, tx_eof1, busy1;
    logic [71:0] in_word1;
    logic [7:0]  tx_byte1;
    logic [15:0] frames1;

    instr_word_tx dut0 (
        .clock(clock), .resetN(resetN),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_word(in_word0),
        .tx_valid(tx_valid0), .tx_ready(tx_ready0), .tx_byte(tx_byte0),
        .tx_sof(tx_sof0), .tx_eof(tx_eof0), .busy(busy0), .frames_sent(frames0)
    );

    instr_word_tx #(.SEND_CHECKSUM(1'b0), .GAP_CYCLES(2)) dut1 (
        .clock(clock), .resetN(resetN),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_word(in_word1),
        .tx_valid(tx_valid1), .tx_ready(tx_ready1), .tx_byte(tx_byte1),
        .tx_sof(tx_sof1), .tx_eof(tx_eof1), .busy(busy1), .frames_sent(frames1)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [15:0] exp_frames0;

    task automatic chk_v(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    task automatic chk_b(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, required %b", name, act, exp);
    endtask

    function automatic logic [71:0] mk_word(input logic [31:0] addr, input logic [31:0] data,
                                            input logic [7:0] op);
        return {addr, data, op};
    endfunction

    // Frame byte i built from the word's fields; byte 9 is the XOR of bytes 0..8.
    function automatic logic [7:0] ref_byte(input logic [71:0] w, input int i);
        logic [31:0] addr;
        logic [31:0] data;
        logic [7:0]  b [9];
        logic [7:0]  x;
        addr = w[71:40];
        data = w[39:8];
        b[0] = w[7:0];
        for (int k = 0; k < 4; k++) begin
            b[1 + k] = 8'(addr >> (24 - 8 * k));
            b[5 + k] = 8'(data >> (24 - 8 * k));
        end
        x = 8'h00;
        for (int k = 0; k < 9; k++) x = x ^ b[k];
        return (i < 9) ? b[i] : x;
    endfunction

    // One frame through dut0. stall_mask: 3 stall cycles at each marked index.
    // abort_after >= 0 pulls reset asynchronously right after that index transfers.
    task automatic run_frame0(input logic [71:0] w, input logic [9:0] stall_mask,
                              input bit rand_ready, input bit noisy, input int abort_after,
                              output logic [7:0] last_byte);
        int budget;
        int idx;
        int stalls;
        bit done;
        bit aborted;
        logic [7:0] cur;
        last_byte = 8'h00;
        @(negedge clock);
        budget = 0;
        while (!in_ready0 && budget < 50) begin
            @(negedge clock);
            budget++;
        end
        chk_b("in_ready_before_word", in_ready0, 1'b1);
        in_valid0 = 1'b1;
        in_word0  = w;
        tx_ready0 = 1'b0;
        @(negedge clock);
        in_valid0 = 1'b0;
        idx = 0; stalls = 0; budget = 0; done = 1'b0; aborted = 1'b0;
        while (budget < 200 && !done) begin
            budget++;
            if (noisy) begin
                in_valid0 = 1'($urandom_range(0, 1));
                in_word0  = {$urandom(), $urandom(), 8'($urandom())};
            end
            cur = tx_byte0;
            chk_b("tx_valid_in_frame", tx_valid0, 1'b1);
            chk_b("in_ready_low_in_frame", in_ready0, 1'b0);
            chk_b("busy_in_frame", busy0, 1'b1);
            chk_v($sformatf("byte[%0d]", idx), 16'(tx_byte0), 16'(ref_byte(w, idx)));
            chk_b($sformatf("sof[%0d]", idx), tx_sof0, idx == 0);
            chk_b($sformatf("eof[%0d]", idx), tx_eof0, idx == 9);
            if (stall_mask[idx] && stalls < 3) begin
                tx_ready0 = 1'b0;
                stalls++;
            end else if (rand_ready) begin
                tx_ready0 = 1'($urandom_range(0, 1));
            end else begin
                tx_ready0 = 1'b1;
            end
            if (tx_ready0 && idx == 9) in_valid0 = 1'b0;
            @(posedge clock);
            if (tx_ready0) begin
                if (idx == 9) begin
                    last_byte = cur;
                    done = 1'b1;
                end else if (idx == abort_after) begin
                    #2 resetN = 1'b0;
                    #1;
                    chk_b("reset_tx_valid", tx_valid0, 1'b0);
                    chk_b("reset_in_ready", in_ready0, 1'b1);
                    chk_v("reset_frames", frames0, 16'h0000);
                    chk_v("reset_tx_byte", 16'(tx_byte0), 16'h0000);
                    chk_b("reset_busy", busy0, 1'b0);
                    in_valid0 = 1'b0;
                    tx_ready0 = 1'b0;
                    @(negedge clock);
                    resetN = 1'b1;
                    exp_frames0 = 16'h0000;
                    aborted = 1'b1;
                    done = 1'b1;
                end else begin
                    idx++;
                    stalls = 0;
                end
            end
            if (!done) @(negedge clock);
        end
        if (!done) begin
            chk_b("frame_timeout", 1'b0, 1'b1);
        end else if (!aborted) begin
            @(negedge clock);
            exp_frames0 = exp_frames0 + 16'd1;
            chk_b("tx_valid_after_frame", tx_valid0, 1'b0);
            chk_v("frames_sent", frames0, exp_frames0);
            chk_b("in_ready_after_frame", in_ready0, 1'b1);
            chk_b("busy_after_frame", busy0, 1'b0);
        end
        in_valid0 = 1'b0;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [7:0]  op;
        logic [9:0]  stall_mask;
        logic [7:0]  exp_cs;
    } vec_t;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t        vecs [4];
        logic [7:0]  lb;
        logic [71:0] wa;
        logic [71:0] wb;
        logic [71:0] wr;
        int          budget;

        vecs[0] = '{32'hFFFF1000, 32'h00000032, 8'h11, 10'b00_0000_0000, 8'h33};
        vecs[1] = '{32'hFFFF1000, 32'h00000032, 8'h11, 10'b10_0001_0001, 8'h33};
        vecs[2] = '{32'h01020304, 32'h05060708, 8'hA0, 10'b00_0000_0100, 8'hA8};
        vecs[3] = '{32'hDEADBEEF, 32'h00000000, 8'h5A, 10'b00_1000_0000, 8'h78};

        resetN = 1'b0;
        in_valid0 = 1'b0; in_word0 = '0; tx_ready0 = 1'b0;
        in_valid1 = 1'b0; in_word1 = '0; tx_ready1 = 1'b0;
        exp_frames0 = 16'h0000;
        #12;
        chk_b("rst_in_ready", in_ready0, 1'b1);
        chk_b("rst_tx_valid", tx_valid0, 1'b0);
        chk_v("rst_tx_byte", 16'(tx_byte0), 16'h0000);
        chk_b("rst_sof", tx_sof0, 1'b0);
        chk_b("rst_eof", tx_eof0, 1'b0);
        chk_b("rst_busy", busy0, 1'b0);
        chk_v("rst_frames", frames0, 16'h0000);
        @(negedge clock);
        resetN = 1'b1;

        // Table: basic frame, backpressure at 0/4/9, further words with stalls.
        for (int i = 0; i < 4; i++) begin
            run_frame0(mk_word(vecs[i].addr, vecs[i].data, vecs[i].op), vecs[i].stall_mask,
                       1'b0, 1'b0, -1, lb);
            chk_v($sformatf("checksum_vec%0d", i), 16'(lb), 16'(vecs[i].exp_cs));
        end

        // Input toggling during SEND must not disturb the latched word.
        run_frame0(mk_word(32'hFFFF1000, 32'h00000032, 8'h11), 10'd0, 1'b0, 1'b1, -1, lb);

        // Reset after byte 4 transfers, then a fresh frame.
        run_frame0(mk_word(32'hFFFF1000, 32'h00000032, 8'h11), 10'd0, 1'b0, 1'b0, 4, lb);
        run_frame0(mk_word(32'h01020304, 32'h05060708, 8'hA0), 10'd0, 1'b0, 1'b0, -1, lb);
        chk_v("frames_after_reset_frame", frames0, 16'h0001);

        // Counter wrap.
        @(negedge clock);
        force dut0.frames_q = 16'hFFFF;
        #1 release dut0.frames_q;
        chk_v("frames_forced", frames0, 16'hFFFF);
        exp_frames0 = 16'hFFFF;
        run_frame0(mk_word(32'h0BADF00D, 32'h12345678, 8'h3C), 10'd0, 1'b0, 1'b0, -1, lb);
        chk_v("frames_wrapped", frames0, 16'h0000);

        // Random words with random backpressure and input noise.
        for (int i = 0; i < 20; i++) begin
            wr = {$urandom(), $urandom(), 8'($urandom())};
            run_frame0(wr, 10'd0, 1'b1, 1'(i % 2), -1, lb);
        end

        // dut1: 9-byte frames, two idle gap cycles, second word offered back-to-back.
        wa = mk_word(32'hFFFF1000, 32'h00000032, 8'h11);
        wb = mk_word(32'hCAFE0001, 32'h87654321, 8'h7E);
        @(negedge clock);
        budget = 0;
        while (!in_ready1 && budget < 50) begin
            @(negedge clock);
            budget++;
        end
        chk_b("d1_in_ready_start", in_ready1, 1'b1);
        in_valid1 = 1'b1;
        in_word1  = wa;
        tx_ready1 = 1'b1;
        @(negedge clock);
        in_word1 = wb;
        for (int i = 0; i < 9; i++) begin
            chk_b($sformatf("d1a_valid[%0d]", i), tx_valid1, 1'b1);
            chk_v($sformatf("d1a_byte[%0d]", i), 16'(tx_byte1), 16'(ref_byte(wa, i)));
            chk_b($sformatf("d1a_sof[%0d]", i), tx_sof1, i == 0);
            chk_b($sformatf("d1a_eof[%0d]", i), tx_eof1, i == 8);
            chk_b($sformatf("d1a_in_ready[%0d]", i), in_ready1, 1'b0);
            if (i == 8) chk_v("d1a_eof_byte", 16'(tx_byte1), 16'h0032);
            @(negedge clock);
        end
        for (int k = 1; k <= 2; k++) begin
            chk_b($sformatf("d1_gap_in_ready[%0d]", k), in_ready1, 1'b0);
            chk_b($sformatf("d1_gap_tx_valid[%0d]", k), tx_valid1, 1'b0);
            chk_b($sformatf("d1_gap_busy[%0d]", k), busy1, 1'b1);
            @(negedge clock);
        end
        chk_b("d1_idle_in_ready", in_ready1, 1'b1);
        chk_b("d1_idle_tx_valid", tx_valid1, 1'b0);
        chk_b("d1_idle_busy", busy1, 1'b0);
        chk_v("d1_frames_1", frames1, 16'h0001);
        @(negedge clock);
        in_valid1 = 1'b0;
        for (int i = 0; i < 9; i++) begin
            chk_b($sformatf("d1b_valid[%0d]", i), tx_valid1, 1'b1);
            chk_v($sformatf("d1b_byte[%0d]", i), 16'(tx_byte1), 16'(ref_byte(wb, i)));
            chk_b($sformatf("d1b_sof[%0d]", i), tx_sof1, i == 0);
            chk_b($sformatf("d1b_eof[%0d]", i), tx_eof1, i == 8);
            @(negedge clock);
        end
        chk_v("d1_frames_2", frames1, 16'h0002);
        repeat (3) @(negedge clock);
        chk_b("d1_final_tx_valid", tx_valid1, 1'b0);
        chk_b("d1_final_in_ready", in_ready1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
